// File: rtl/pla_and_or_scan_if.sv
// pla_and_or_scan_if: operand/result handshake bundle for pla_and_or_scan
interface pla_and_or_scan_if #(parameter int WIDTH = 65) ();
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic             z0;
  logic [CNT_W-1:0] match_cnt;
  logic             first_found;
  logic [IDX_W-1:0] first_idx;
  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, z0, match_cnt, first_found, first_idx
  );
  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, z0, match_cnt, first_found, first_idx
  );
endinterface

// File: rtl/pla_and_or_scan.sv
// pla_and_or_scan: chunked sequential AND-OR scan with match count and lowest match index
module pla_and_or_scan #(
  parameter int WIDTH = 65,
  parameter int CHUNK = 16
) (
  input logic               clk,
  input logic               rst,
  pla_and_or_scan_if.slave  bus
);
  localparam int NCH   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int KW    = NCH > 1 ? $clog2(NCH) : 1;
  localparam int PW    = NCH * CHUNK;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           r_state, w_next;
  logic [PW-1:0]    r_a, r_b;
  logic             r_mode;
  logic [KW-1:0]    r_k;
  logic             r_z0, r_ff;
  logic [CNT_W-1:0] r_cnt, w_pop;
  logic [IDX_W-1:0] r_idx, w_low, w_base;
  logic [PW-1:0]    w_sa, w_sb;
  logic [CHUNK-1:0] w_and;
  logic             w_any, w_last;
  // operands are zero-padded to whole chunks, which masks bits >= WIDTH
  assign w_sa   = r_a >> (32'(r_k) * CHUNK);
  assign w_sb   = r_b >> (32'(r_k) * CHUNK);
  assign w_and  = w_sa[CHUNK-1:0] & w_sb[CHUNK-1:0];
  assign w_any  = |w_and;
  assign w_last = r_k == KW'(NCH - 1);
  assign w_base = IDX_W'(32'(r_k) * CHUNK);
  always_comb begin
    w_pop = '0;
    w_low = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      w_pop = w_pop + CNT_W'(w_and[i]);
      w_low = w_and[i] ? IDX_W'(i) : w_low;
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.in_valid ? SCAN : IDLE)
           : r_state == SCAN ? ((w_last || (!r_mode && w_any)) ? DONE : SCAN)
           : (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_k     <= '0;
      r_z0    <= 1'b0;
      r_ff    <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_a    <= PW'(bus.a);
        r_b    <= PW'(bus.b);
        r_mode <= bus.mode;
        r_k    <= '0;
        r_z0   <= 1'b0;
        r_ff   <= 1'b0;
        r_cnt  <= '0;
        r_idx  <= '0;
      end else if (r_state == SCAN) begin
        r_cnt <= r_cnt + w_pop;
        r_k   <= r_k + KW'(1);
        if (!r_ff && w_any) begin
          r_ff  <= 1'b1;
          r_z0  <= 1'b1;
          r_idx <= w_base + w_low;
        end
      end
    end
  end
  assign bus.in_ready    = r_state == IDLE;
  assign bus.out_valid   = r_state == DONE;
  assign bus.z0          = r_z0;
  assign bus.match_cnt   = r_cnt;
  assign bus.first_found = r_ff;
  assign bus.first_idx   = r_idx;
endmodule

// File: tb/tb_pla_and_or_scan.sv
// tb_pla_and_or_scan: directed self-checking bench for pla_and_or_scan at default parameters
module tb_pla_and_or_scan;
  localparam int WIDTH = 65;
  localparam int CHUNK = 16;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = 65'd1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  pla_and_or_scan_if #(.WIDTH(WIDTH)) bus ();
  pla_and_or_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // lat: edge index (accept edge = 0) whose preceding cycle first shows out_valid; 0 on timeout
  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vm, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = va;
    bus.b = vb;
    bus.mode = vm;
    for (int n = 0; n < 50 && !bus.in_ready; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z0 !== 1'b0 || bus.match_cnt !== 7'd0 || bus.first_found !== 1'b0 || bus.first_idx !== 7'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b ov=%b z0=%b cnt=%0d ff=%b idx=%0d exp rdy=1 ov=0 z0=0 cnt=0 ff=0 idx=0", bus.in_ready, bus.out_valid, bus.z0, bus.match_cnt, bus.first_found, bus.first_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_scan(input string nm, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vm,
                           input int elat, input logic ez0, input int ecnt, input logic eff, input int eidx);
    int lat;
    issue(va, vb, vm, lat);
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, elat);
    end
    checks++;
    if (bus.z0 !== ez0 || bus.match_cnt !== 7'(ecnt) || bus.first_found !== eff || bus.first_idx !== 7'(eidx)) begin
      failures++;
      $display("FAIL %s_result got z0=%b cnt=%0d ff=%b idx=%0d exp z0=%b cnt=%0d ff=%b idx=%0d", nm, bus.z0, bus.match_cnt, bus.first_found, bus.first_idx, ez0, ecnt, eff, eidx);
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(ONE << 10, ONE << 10, 1'b1, lat);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL bp_latency got=%0d exp=6", lat);
    end
    bus.in_valid = 1'b1;
    bus.a = ONES;
    bus.b = ONES;
    bus.mode = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.z0 !== 1'b1 || bus.match_cnt !== 7'd1 || bus.first_idx !== 7'd10) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got ov=%b rdy=%b z0=%b cnt=%0d idx=%0d exp ov=1 rdy=0 z0=1 cnt=1 idx=10", n, bus.out_valid, bus.in_ready, bus.z0, bus.match_cnt, bus.first_idx);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
    test_scan("bp_next", ONES, ONES, 1'b1, 6, 1'b1, 65, 1'b1, 0);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = ONES;
    bus.b = ONES;
    bus.mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z0 !== 1'b0 || bus.match_cnt !== 7'd0 || bus.first_found !== 1'b0 || bus.first_idx !== 7'd0) begin
      failures++;
      $display("FAIL midreset_state got rdy=%b ov=%b z0=%b cnt=%0d ff=%b idx=%0d exp rdy=1 ov=0 z0=0 cnt=0 ff=0 idx=0", bus.in_ready, bus.out_valid, bus.z0, bus.match_cnt, bus.first_found, bus.first_idx);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_no_result cyc=%0d got ov=%b exp ov=0", n, bus.out_valid);
      end
    end
    test_scan("midreset_next", ONE << 5, ONES, 1'b0, 2, 1'b1, 1, 1'b1, 5);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mode = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_scan("zero", '0, '0, 1'b1, 6, 1'b0, 0, 1'b0, 0);
    test_scan("ones", ONES, ONES, 1'b1, 6, 1'b1, 65, 1'b1, 0);
    test_scan("early_any", ONE | (ONE << 40), ONE | (ONE << 40), 1'b0, 2, 1'b1, 1, 1'b1, 0);
    test_scan("early_count", ONE | (ONE << 40), ONE | (ONE << 40), 1'b1, 6, 1'b1, 2, 1'b1, 0);
    test_scan("last_bit", ONE << 64, ONE << 64, 1'b0, 6, 1'b1, 1, 1'b1, 64);
    test_scan("complement", 65'h1_FFFF_FFFF_FFFF_FFFF, ~65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1, 6, 1'b0, 0, 1'b0, 0);
    test_scan("chunk2_exit", (ONE << 35) | (ONE << 50), ONES, 1'b0, 4, 1'b1, 1, 1'b1, 35);
    test_scan("multi_chunk1", (ONE << 20) | (ONE << 21) | (ONE << 22) | (ONE << 63), ONES, 1'b0, 3, 1'b1, 3, 1'b1, 20);
    test_scan("partial_a", ONES ^ (ONE << 3), ONE << 3 | ONE << 47 | ONE << 48, 1'b1, 6, 1'b1, 2, 1'b1, 47);
    test_backpressure();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pla_and_or_scan.md
Name: pla_and_or_scan

Overview:
- Parametrised, sequential successor to the flat two-level AND-OR product-term blocks.
- Takes two WIDTH-bit operand vectors A and B through a valid/ready handshake.
- Scans them CHUNK bits per cycle and reports:
  - z0 = OR over i of (A[i] & B[i]);
  - match count;
  - lowest matching bit index.
- Replaces wide single-level AND-OR planes where area matters more than latency. Sits between an operand register stage and a result consumer.

Parameters:
WIDTH, 65, operand vector width in bits (>=1)
CHUNK, 16, bits evaluated per SCAN cycle (1..WIDTH)
NCH, ceil(WIDTH/CHUNK) (derived, 5 at defaults), number of chunks
CNT_W, clog2(WIDTH+1) (derived, 7 at defaults), match_cnt width
IDX_W, max(1,clog2(WIDTH)) (derived, 7 at defaults), first_idx width

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand vector A
b  input  WIDTH  operand vector B
mode  input  1  0 = ANY (early exit on first match), 1 = COUNT (full scan); sampled with operands
out_valid  output  1  result valid, held until taken
out_ready  input  1  consumer accepts result
z0  output  1  OR of (A & B) over scanned bits
match_cnt  output  CNT_W  number of i with A[i]&B[i] over scanned chunks
first_found  output  1  at least one match found
first_idx  output  IDX_W  lowest matching bit index; 0 when first_found=0

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; in_ready=1; out_valid=0; z0=0; match_cnt=0; first_found=0; first_idx=0; chunk pointer=0.
  - Reset mid-SCAN or in DONE aborts the operation; no result is ever presented for it.
- States:
  - IDLE: in_ready=1.
    - On in_valid&in_ready, latch a, b, mode.
    - Clear z0, match_cnt, first_found and first_idx.
    - Set pointer k=0 and go to SCAN.
  - SCAN: in_ready=0.
    - Each cycle evaluate bits [k*CHUNK .. k*CHUNK+CHUNK-1] of the latched operands.
    - Bits >= WIDTH in the last chunk are masked to 0.
    - match_cnt += popcount(chunk AND).
    - If not first_found and the chunk has any match: first_found=1, z0=1, first_idx = k*CHUNK + lowest set position in the chunk.
    - Exit to DONE when k==NCH-1, or when mode=0 and this chunk produced a match (early exit). Otherwise k++.
  - DONE: out_valid=1; all result outputs held stable.
    - On out_ready, go to IDLE. out_valid falls and in_ready rises the following cycle.
    - in_valid is ignored in SCAN and DONE; there is no overlap between operations.
- Latency: accept at edge T.
  - Full scan: out_valid=1 from T+NCH+1.
  - Early exit at chunk k: out_valid=1 from T+k+2.
  - Minimum issue interval: NCH+2 cycles with out_ready tied high.
- Mode 0 match_cnt counts only the chunks actually scanned, up to and including the exit chunk.
- Result outputs change only on the SCAN cycles of an operation and on accept/reset clears. They are never undefined.
- Arithmetic:
  - match_cnt saturates naturally; the maximum is WIDTH, which always fits in CNT_W.
  - first_idx < WIDTH always.
- Degenerate case CHUNK >= WIDTH: NCH=1, single SCAN cycle.

Test Plan:
- Defaults; a=b=0, mode=1, accept at T -> out_valid at T+6; z0=0, match_cnt=0, first_found=0, first_idx=0.
- a=b=all ones, mode=1 -> out_valid at T+6; z0=1, match_cnt=65, first_found=1, first_idx=0.
- a[0]=b[0]=1, a[40]=b[40]=1, mode=0 -> early exit, out_valid at T+2; z0=1, first_idx=0, match_cnt=1. Same stimulus with mode=1 -> out_valid at T+6, match_cnt=2.
- Only a[64]=b[64]=1 (partial last chunk), a[65..] n/a, mode=0 -> out_valid at T+6; first_idx=64, match_cnt=1. Also a=0x1_FFFF_FFFF_FFFF_FFFF, b=~a -> z0=0.
- Backpressure: result ready, out_ready=0 for 10 cycles while in_valid=1 with new operands -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> in_ready=1 next cycle; new operation accepted.
- Assert rst during SCAN at k=2 -> next cycle state IDLE, out_valid=0, in_ready=1, all results 0. A subsequent operation completes normally.
